// File: rtl/mms_pkg.sv
// Shared definitions for the MAC Merge verify controller: state codes and default limits.
package mms_pkg;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_SEND     = 3'd2,
    ST_WAIT     = 3'd3,
    ST_VERIFIED = 3'd4,
    ST_FAIL     = 3'd5
  } state_t;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int unsigned DEF_VERIFY_LIMIT = 3;
  localparam int unsigned DEF_VERIFY_TIME  = 10;

endpackage

// File: rtl/mms_tick_timer.sv
// Loadable down-counter advanced by a timebase strobe; done while the count is zero.
module mms_tick_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         done
);

  logic [W-1:0] count_q;

  // Load wins over tick; the count parks at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (tick && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/mms_verify_ctrl.sv
// MAC Merge verify handshake controller: sends verify mPackets, times responses,
// and reports verified / failed status with an optional autonomous retry.
module mms_verify_ctrl
  import mms_pkg::*;
#(
  parameter int unsigned VERIFY_LIMIT  = DEF_VERIFY_LIMIT,
  parameter int unsigned VERIFY_TIME   = DEF_VERIFY_TIME,
  parameter int unsigned TIMER_W       = 8,
  parameter int unsigned CNT_W         = $clog2(VERIFY_LIMIT + 1),
  parameter int unsigned RETRY_ON_FAIL = 0,
  parameter int unsigned RETRY_HOLDOFF = 100,
  parameter int unsigned FAIL_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reset_begin,
  input  logic              link_fail,
  input  logic              disable_verify,
  input  logic              p_enable,
  input  logic              tick,
  input  logic              send_v_done,
  input  logic              rcv_r,
  output logic              send_v,
  output logic              clr_flags,
  output logic              verified,
  output logic              verify_fail,
  output logic [CNT_W-1:0]  verify_cnt,
  output logic [FAIL_W-1:0] fail_cnt,
  output logic [2:0]        state
);

  localparam int unsigned HOLD_W   = (RETRY_HOLDOFF < 1) ? 1 : $clog2(RETRY_HOLDOFF + 1);
  localparam logic        RETRY_EN = (RETRY_ON_FAIL != 0);

  state_t state_q, state_nxt;
  logic   rst_pending_q;
  logic   force_init;
  logic   vt_load, vt_tick, vt_done;
  logic   hold_load, hold_tick, hold_done;
  logic   fail_entry;

  logic              send_v_nxt, clr_flags_nxt, verified_nxt, verify_fail_nxt;
  logic [CNT_W-1:0]  verify_cnt_nxt;
  logic [FAIL_W-1:0] fail_cnt_nxt;

  assign force_init = reset_begin | link_fail | disable_verify | ~p_enable;

  // Timers only advance in the state that owns them and freeze under a force.
  assign vt_tick   = tick & (state_q == ST_WAIT) & ~force_init;
  assign hold_tick = tick & (state_q == ST_FAIL) & ~force_init;

  mms_tick_timer #(.W(TIMER_W)) u_verify_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (vt_load),
    .load_val (TIMER_W'(VERIFY_TIME)),
    .tick     (vt_tick),
    .done     (vt_done)
  );

  mms_tick_timer #(.W(HOLD_W)) u_holdoff_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (hold_load),
    .load_val (HOLD_W'(RETRY_HOLDOFF)),
    .tick     (hold_tick),
    .done     (hold_done)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      rst_pending_q <= TRUE;
      send_v        <= FALSE;
      clr_flags     <= FALSE;
      verified      <= FALSE;
      verify_fail   <= FALSE;
      verify_cnt    <= '0;
      fail_cnt      <= '0;
    end else begin
      state_q       <= state_nxt;
      rst_pending_q <= FALSE;
      send_v        <= send_v_nxt;
      clr_flags     <= clr_flags_nxt;
      verified      <= verified_nxt;
      verify_fail   <= verify_fail_nxt;
      verify_cnt    <= verify_cnt_nxt;
      fail_cnt      <= fail_cnt_nxt;
    end
  end

  // Next state; the force has priority and unused codes recover to INIT.
  always_comb begin
    state_nxt = state_q;
    if (force_init) begin
      state_nxt = ST_INIT;
    end else begin
      case (state_q)
        ST_INIT:     state_nxt = ST_IDLE;
        ST_IDLE:     if (p_enable && !disable_verify) state_nxt = ST_SEND;
        ST_SEND:     if (send_v_done) state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (rcv_r) begin
            state_nxt = ST_VERIFIED;
          end else if (vt_done) begin
            if (verify_cnt < CNT_W'(VERIFY_LIMIT)) state_nxt = ST_IDLE;
            else                                   state_nxt = ST_FAIL;
          end
        end
        ST_VERIFIED: state_nxt = ST_VERIFIED;
        ST_FAIL:     if (RETRY_EN && hold_done) state_nxt = ST_INIT;
        default:     state_nxt = ST_INIT;
      endcase
    end
  end

  // Entry actions, computed from the transition and registered with it.
  always_comb begin
    send_v_nxt      = FALSE;
    clr_flags_nxt   = FALSE;
    verified_nxt    = FALSE;
    verify_fail_nxt = FALSE;
    verify_cnt_nxt  = verify_cnt;
    fail_cnt_nxt    = fail_cnt;
    vt_load         = FALSE;
    hold_load       = FALSE;
    fail_entry      = (state_nxt == ST_FAIL) && (state_q != ST_FAIL);

    // The reset release counts as an INIT entry for the flag-clear pulse.
    clr_flags_nxt   = rst_pending_q || ((state_nxt == ST_INIT) && (state_q != ST_INIT));
    send_v_nxt      = (state_nxt == ST_SEND);
    verified_nxt    = (state_nxt == ST_VERIFIED);
    verify_fail_nxt = (state_nxt == ST_FAIL);

    if (state_nxt == ST_INIT) begin
      verify_cnt_nxt = '0;
    end else if ((state_q == ST_SEND) && (state_nxt == ST_WAIT)) begin
      vt_load = TRUE;
      if (verify_cnt != '1) verify_cnt_nxt = verify_cnt + CNT_W'(1);
    end

    if (fail_entry) begin
      hold_load = TRUE;
      if (fail_cnt != '1) fail_cnt_nxt = fail_cnt + FAIL_W'(1);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mms_verify_ctrl.sv
// Directed bench for mms_verify_ctrl: default instance plus a retry-mode instance.
module tb_mms_verify_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  // Default-parameter instance
  logic       reset_begin, link_fail, disable_verify, p_enable, tick, send_v_done, rcv_r;
  logic       send_v, clr_flags, verified, verify_fail;
  logic [1:0] verify_cnt;
  logic [7:0] fail_cnt;
  logic [2:0] state;

  // Retry-mode instance
  logic       r_reset_begin, r_link_fail, r_disable_verify, r_p_enable, r_tick, r_send_v_done, r_rcv_r;
  logic       r_send_v, r_clr_flags, r_verified, r_verify_fail;
  logic [0:0] r_verify_cnt;
  logic [7:0] r_fail_cnt;
  logic [2:0] r_state;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_clr    = 0;
  int   n_sendv  = 0;
  logic send_v_prev = 1'b0;

  always #5 clk = ~clk;

  mms_verify_ctrl #(
    .VERIFY_LIMIT(3), .VERIFY_TIME(10), .TIMER_W(8), .CNT_W(2),
    .RETRY_ON_FAIL(0), .RETRY_HOLDOFF(100), .FAIL_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .reset_begin(reset_begin), .link_fail(link_fail),
    .disable_verify(disable_verify), .p_enable(p_enable), .tick(tick),
    .send_v_done(send_v_done), .rcv_r(rcv_r), .send_v(send_v), .clr_flags(clr_flags),
    .verified(verified), .verify_fail(verify_fail), .verify_cnt(verify_cnt),
    .fail_cnt(fail_cnt), .state(state)
  );

  mms_verify_ctrl #(
    .VERIFY_LIMIT(1), .VERIFY_TIME(2), .TIMER_W(8), .CNT_W(1),
    .RETRY_ON_FAIL(1), .RETRY_HOLDOFF(5), .FAIL_W(8)
  ) dut_r (
    .clk(clk), .rst_n(rst_n), .reset_begin(r_reset_begin), .link_fail(r_link_fail),
    .disable_verify(r_disable_verify), .p_enable(r_p_enable), .tick(r_tick),
    .send_v_done(r_send_v_done), .rcv_r(r_rcv_r), .send_v(r_send_v), .clr_flags(r_clr_flags),
    .verified(r_verified), .verify_fail(r_verify_fail), .verify_cnt(r_verify_cnt),
    .fail_cnt(r_fail_cnt), .state(r_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (clr_flags) n_clr++;
    if (send_v && !send_v_prev) n_sendv++;
    send_v_prev = send_v;
  endtask

  // Wait (bounded) for send_v, acknowledge it, and land in WAIT_FOR_RESPONSE.
  task automatic send_and_ack(input int exp_cnt);
    for (int k = 0; k < 20 && !send_v; k++) step();
    check("send_v_seen", send_v, 1);
    send_v_done = 1'b1;
    step();
    send_v_done = 1'b0;
    check("ack_state_wait", state, 3);
    check("ack_send_v_low", send_v, 0);
    check("ack_verify_cnt", verify_cnt, exp_cnt);
  endtask

  // Ten ticks drain the verify timer; the FSM is still in WAIT afterwards.
  task automatic expire();
    for (int j = 0; j < 10; j++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      if (j == 8) check("wait_pre_expire", state, 3);
    end
    check("wait_at_zero", state, 3);
  endtask

  // Force pulse through reset_begin, then INIT -> IDLE -> SEND.
  task automatic restart();
    reset_begin = 1'b1;
    step();
    reset_begin = 1'b0;
    check("restart_init", state, 0);
    step();
    step();
    check("restart_send", state, 2);
  endtask

  // One complete failure and hold-off on the retry instance, starting from INIT.
  task automatic r_fail_cycle(input int exp_fail);
    step();
    check("r_idle", r_state, 1);
    step();
    check("r_send", r_state, 2);
    check("r_send_v", r_send_v, 1);
    r_send_v_done = 1'b1;
    step();
    r_send_v_done = 1'b0;
    check("r_wait", r_state, 3);
    r_tick = 1'b1;
    step();
    step();
    r_tick = 1'b0;
    check("r_wait_at_zero", r_state, 3);
    step();
    check("r_fail", r_state, 5);
    check("r_verify_fail", r_verify_fail, 1);
    check("r_fail_cnt", r_fail_cnt, exp_fail);
    step();
    step();
    check("r_hold_no_tick", r_state, 5);
    for (int j = 0; j < 5; j++) begin
      r_tick = 1'b1;
      step();
      r_tick = 1'b0;
      check("r_holdoff", r_state, 5);
    end
    step();
    check("r_retry_init", r_state, 0);
    check("r_retry_vfail_clr", r_verify_fail, 0);
    check("r_retry_clr_flags", r_clr_flags, 1);
    check("r_retry_fail_kept", r_fail_cnt, exp_fail);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int entries;
    logic prev_fail;

    rst_n = 1'b0;
    {reset_begin, link_fail, disable_verify, tick, send_v_done, rcv_r} = '0;
    p_enable = 1'b1;
    {r_reset_begin, r_link_fail, r_disable_verify, r_p_enable, r_tick, r_send_v_done, r_rcv_r} = '0;

    // Reset state
    step();
    step();
    check("rst_state", state, 0);
    check("rst_send_v", send_v, 0);
    check("rst_clr_flags", clr_flags, 0);
    check("rst_verified", verified, 0);
    check("rst_verify_fail", verify_fail, 0);
    check("rst_verify_cnt", verify_cnt, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    n_clr = 0;
    rst_n = 1'b1;

    // 1. Normal verify
    step();
    check("t1_idle", state, 1);
    check("t1_clr_pulse", clr_flags, 1);
    step();
    check("t1_send", state, 2);
    check("t1_send_v", send_v, 1);
    check("t1_clr_low", clr_flags, 0);
    step();
    step();
    check("t1_send_hold", send_v, 1);
    send_and_ack(1);
    for (int j = 0; j < 4; j++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
    check("t1_still_wait", state, 3);
    rcv_r = 1'b1;
    step();
    check("t1_verified_state", state, 4);
    check("t1_verified", verified, 1);
    check("t1_verify_cnt", verify_cnt, 1);
    check("t1_clr_count", n_clr, 1);

    // 2. Exhaust limit
    rcv_r = 1'b0;
    disable_verify = 1'b1;
    step();
    check("t2_force_init", state, 0);
    check("t2_verified_clr", verified, 0);
    check("t2_cnt_clr", verify_cnt, 0);
    disable_verify = 1'b0;
    base = n_sendv;
    for (int i = 1; i <= 3; i++) begin
      send_and_ack(i);
      expire();
      step();
      check("t2_after_expire", state, (i < 3) ? 1 : 5);
    end
    check("t2_send_pulses", n_sendv - base, 3);
    check("t2_verify_cnt", verify_cnt, 3);
    check("t2_verify_fail", verify_fail, 1);
    check("t2_fail_cnt", fail_cnt, 1);
    tick = 1'b1;
    send_v_done = 1'b1;
    step();
    step();
    step();
    tick = 1'b0;
    send_v_done = 1'b0;
    check("t2_fail_terminal", state, 5);
    check("t2_fail_cnt_once", fail_cnt, 1);

    // rcv_r already high in SEND is honoured on the first WAIT cycle
    restart();
    check("fail_cnt_kept", fail_cnt, 1);
    check("vfail_cleared", verify_fail, 0);
    rcv_r = 1'b1;
    step();
    check("early_rcv_send", state, 2);
    send_and_ack(1);
    step();
    check("early_rcv_verified", state, 4);
    rcv_r = 1'b0;

    // 3. rcv_r and final timer expiry together
    restart();
    for (int i = 1; i <= 3; i++) begin
      send_and_ack(i);
      expire();
      if (i < 3) begin
        step();
        check("t3_to_idle", state, 1);
      end
    end
    rcv_r = 1'b1;
    step();
    check("t3_simul_verified", state, 4);
    check("t3_no_vfail", verify_fail, 0);
    check("t3_fail_cnt", fail_cnt, 1);
    rcv_r = 1'b0;

    // 4. link_fail in WAIT with verify_cnt=2
    restart();
    send_and_ack(1);
    expire();
    step();
    send_and_ack(2);
    for (int j = 0; j < 3; j++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
    base = n_clr;
    link_fail = 1'b1;
    step();
    check("t4_state", state, 0);
    check("t4_verify_cnt", verify_cnt, 0);
    check("t4_send_v", send_v, 0);
    check("t4_clr", clr_flags, 1);
    for (int j = 0; j < 4; j++) begin
      step();
      check("t4_hold_init", state, 0);
    end
    link_fail = 1'b0;
    check("t4_clr_once", n_clr - base, 1);
    step();
    check("t4_restart_idle", state, 1);
    step();
    check("t4_restart_send", state, 2);
    check("t4_restart_send_v", send_v, 1);

    // 5. Retry mode
    r_p_enable = 1'b1;
    r_fail_cycle(1);
    r_fail_cycle(2);
    r_fail_cycle(3);
    r_tick = 1'b1;
    for (int k = 0; k < 6000 && r_fail_cnt != 8'd255; k++) begin
      step();
      r_send_v_done = r_send_v;
    end
    check("r_fail_cnt_255", r_fail_cnt, 255);
    entries = 0;
    prev_fail = (r_state == 3'd5);
    for (int k = 0; k < 60; k++) begin
      step();
      r_send_v_done = r_send_v;
      if (r_state == 3'd5 && !prev_fail) entries++;
      prev_fail = (r_state == 3'd5);
    end
    check("r_more_fail_entries", (entries >= 3) ? 1 : 0, 1);
    check("r_fail_cnt_sat", r_fail_cnt, 255);
    r_tick = 1'b0;
    r_send_v_done = 1'b0;

    // 6. Async reset mid SEND_VERIFY
    check("t6_pre_state", state, 2);
    check("t6_pre_fail_cnt", fail_cnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_state", state, 0);
    check("t6_send_v", send_v, 0);
    check("t6_clr_flags", clr_flags, 0);
    check("t6_verified", verified, 0);
    check("t6_verify_fail", verify_fail, 0);
    check("t6_verify_cnt", verify_cnt, 0);
    check("t6_fail_cnt", fail_cnt, 0);
    check("t6_r_fail_cnt", r_fail_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
